// File: rtl/rv_mem_pkg.sv
// Shared encodings and access-formatting helpers for the memory-access stage.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    LNONE = 3'd0,
    LB    = 3'd1,
    LH    = 3'd2,
    LW    = 3'd3,
    LBU   = 3'd4,
    LHU   = 3'd5
  } load_t;

  typedef enum logic [1:0] {
    SNONE = 2'd0,
    SB    = 2'd1,
    SH    = 2'd2,
    SW    = 2'd3
  } store_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Natural alignment; a nonzero load code wins over any store code.
  // Unknown load codes are treated as word accesses.
  function automatic logic mem_aligned(logic [2:0] ld, store_t st, logic [1:0] off);
    if (ld != LNONE) begin
      case (ld)
        LB, LBU: return 1'b1;
        LH, LHU: return ~off[0];
        default: return (off == 2'b00);
      endcase
    end
    case (st)
      SH:      return ~off[0];
      SW:      return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Byte enables for a store landing at byte offset off.
  function automatic logic [3:0] store_be(store_t st, logic [1:0] off);
    case (st)
      SB:      return 4'b0001 << off;
      SH:      return 4'b0011 << off;
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane so the enables pick the right one.
  function automatic logic [31:0] store_wdata(store_t st, logic [31:0] rs2);
    case (st)
      SB:      return {4{rs2[7:0]}};
      SH:      return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_formatter.sv
// Extracts and extends the addressed byte/half/word from a read word.
module load_formatter
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Sign- or zero-extend the low lane of the shifted word.
  always_comb begin
    result = rdata;
    case (load_type)
      LB:      result = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     result = {24'b0, shifted[7:0]};
      LH:      result = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     result = {16'b0, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding dmem bus master plus write-back bundle.
module mem_access
  import rv_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic        misaligned_err,
  output logic        bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t      state, state_d;
  store_t      st_in;
  logic        is_load, is_store, is_mem, aligned, timeout;
  logic        is_load_q, wreg_q;
  logic [2:0]  ld_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q;
  logic [31:0] ld_fmt;
  logic [CW-1:0] cnt;

  assign st_in    = store_t'(info_storeE);
  assign is_load  = (info_loadE != LNONE);
  assign is_store = ~is_load & (info_storeE != SNONE);
  assign is_mem   = is_load | is_store;
  assign aligned  = mem_aligned(info_loadE, st_in, alu_result[1:0]);
  // Counter holds the number of REQ cycles already spent without ack.
  assign timeout  = (cnt == CW'(ACK_TIMEOUT - 1));

  load_formatter u_fmt (
    .rdata     (dmem_rdata),
    .offset    (off_q),
    .load_type (ld_q),
    .result    (ld_fmt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next state and upstream stall; stall covers the accept, REQ and RESP cycles.
  always_comb begin
    state_d = state;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && is_mem && aligned) begin
          state_d = ST_REQ;
          stall   = 1'b1;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        // Ack wins over a simultaneous timeout.
        if (dmem_ack)     state_d = ST_RESP;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_RESP: begin
        stall   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus request, latched op context and write-back bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      write_regM     <= 1'b0;
      dstreg_addrM   <= '0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
      is_load_q      <= 1'b0;
      wreg_q         <= 1'b0;
      ld_q           <= '0;
      off_q          <= '0;
      rd_q           <= '0;
      alu_q          <= '0;
      cnt            <= '0;
    end else begin
      wb_valid       <= 1'b0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_result;
              write_regM   <= write_regE;
              dstreg_addrM <= dstreg_addrE;
            end else if (!aligned) begin
              wb_valid       <= 1'b1;
              misaligned_err <= 1'b1;
              wb_data        <= alu_result;
              write_regM     <= 1'b0;
              dstreg_addrM   <= dstreg_addrE;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_be    <= is_store ? store_be(st_in, alu_result[1:0]) : 4'b1111;
              dmem_wdata <= store_wdata(st_in, rs2E);
              is_load_q  <= is_load;
              wreg_q     <= write_regE;
              ld_q       <= info_loadE;
              off_q      <= alu_result[1:0];
              rd_q       <= dstreg_addrE;
              alu_q      <= alu_result;
              cnt        <= '0;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + CW'(1);
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= is_load_q ? ld_fmt : alu_q;
            write_regM   <= is_load_q & wreg_q;
            dstreg_addrM <= rd_q;
          end else if (timeout) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            bus_err      <= 1'b1;
            wb_data      <= alu_q;
            write_regM   <= 1'b0;
            dstreg_addrM <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a behavioural write-back scoreboard.
module tb_mem_access;
  import rv_mem_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2E = '0;
  logic        write_regE = 1'b0;
  logic [2:0]  info_loadE = '0;
  logic [1:0]  info_storeE = '0;
  logic [4:0]  dstreg_addrE = '0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        write_regM;
  logic [4:0]  dstreg_addrM;
  logic        misaligned_err, bus_err;

  mem_access #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result), .rs2E(rs2E),
    .write_regE(write_regE), .info_loadE(info_loadE), .info_storeE(info_storeE),
    .dstreg_addrE(dstreg_addrE), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .write_regM(write_regM),
    .dstreg_addrM(dstreg_addrM), .misaligned_err(misaligned_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    bit          wreg;
    logic [4:0]  rd;
    bit          mis;
    bit          berr;
  } exp_t;

  exp_t        q[$];
  exp_t        cmp_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_wb_data = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_be = '0;
  int          last_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the load result: pick the lane arithmetically, extend by value.
  function automatic logic [31:0] model_load(logic [31:0] rdata, int off, logic [2:0] ld);
    logic [31:0] r;
    int v;
    r = rdata >> (8 * off);
    case (ld)
      LB:      begin v = int'(r & 32'hFF);   if (v >= 128)   v = v - 256;   end
      LBU:     v = int'(r & 32'hFF);
      LH:      begin v = int'(r & 32'hFFFF); if (v >= 32768) v = v - 65536; end
      LHU:     v = int'(r & 32'hFFFF);
      default: v = int'(rdata);
    endcase
    return 32'(v);
  endfunction

  // Every write-back pulse is matched against the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        last_wb_data = wb_data;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got wb_valid=1 expected no write-back");
        end else begin
          cmp_e = q.pop_front();
          chk("wb_write_reg", {31'b0, write_regM}, {31'b0, cmp_e.wreg});
          chk("wb_misaligned", {31'b0, misaligned_err}, {31'b0, cmp_e.mis});
          chk("wb_bus_err", {31'b0, bus_err}, {31'b0, cmp_e.berr});
          if (cmp_e.wreg) chk("wb_rd", {27'b0, dstreg_addrM}, {27'b0, cmp_e.rd});
          if (cmp_e.chk_data) chk("wb_data", wb_data, cmp_e.data);
        end
      end else begin
        chk("mis_no_wb", {31'b0, misaligned_err}, 32'd0);
        chk("berr_no_wb", {31'b0, bus_err}, 32'd0);
      end
    end
  end

  // Issue one bundle, play the memory side, and check bus/stall/timing.
  // ack_at: REQ cycle (1-based) on which to ack; 0 or > TMO means never.
  task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic wreg,
                        input int ack_at, input logic [31:0] rdata);
    bit is_ld, is_st, mem, al, acked;
    int size, off, stalls;
    logic [31:0] ew;
    logic [3:0]  eb;
    exp_t e;
    is_ld = (ld != 3'd0);
    is_st = !is_ld && (st != 2'd0);
    mem   = is_ld || is_st;
    if (is_ld) size = (ld == LB || ld == LBU) ? 1 : (ld == LH || ld == LHU) ? 2 : 4;
    else       size = (st == SB) ? 1 : (st == SH) ? 2 : 4;
    al    = (addr % size) == 0;
    acked = (ack_at >= 1) && (ack_at <= TMO);
    off   = int'(addr % 4);
    eb = 4'hF;
    ew = rs2;
    if (is_st && st == SB) begin eb = 4'(1 << off); ew = {24'b0, rs2[7:0]} * 32'h01010101; end
    if (is_st && st == SH) begin eb = 4'(3 << off); ew = {16'b0, rs2[15:0]} * 32'h00010001; end

    e.rd = rd; e.mis = 0; e.berr = 0; e.chk_data = 0; e.wreg = 0; e.data = addr;
    if (!mem)          begin e.wreg = wreg; e.chk_data = 1; end
    else if (!al)      e.mis = 1;
    else if (!acked)   e.berr = 1;
    else if (is_ld)    begin e.wreg = wreg; e.chk_data = 1; e.data = model_load(rdata, off, ld); end
    q.push_back(e);

    in_valid = 1; alu_result = addr; rs2E = rs2; write_regE = wreg;
    info_loadE = ld; info_storeE = st; dstreg_addrE = rd;
    stalls = 0;
    @(negedge clk);
    chk("accept_stall", {31'b0, stall}, {31'b0, mem && al});
    chk("accept_no_req", {31'b0, dmem_req}, 32'd0);
    if (stall) stalls++;
    @(posedge clk); #1;
    in_valid = 0;
    if (mem && al) begin
      for (int j = 1; j <= TMO; j++) begin
        if (j == ack_at) begin dmem_ack = 1; dmem_rdata = rdata; end
        @(negedge clk);
        chk("req_held", {31'b0, dmem_req}, 32'd1);
        chk("req_we", {31'b0, dmem_we}, {31'b0, is_st});
        chk("req_addr", dmem_addr, addr - (addr % 4));
        chk("req_be", {28'b0, dmem_be}, {28'b0, eb});
        if (is_st) chk("req_wdata", dmem_wdata, ew);
        chk("req_no_wb", {31'b0, wb_valid}, 32'd0);
        if (stall) stalls++;
        last_be = dmem_be;
        last_wdata = dmem_wdata;
        @(posedge clk); #1;
        dmem_ack = 0;
        dmem_rdata = '0;
        if (j == ack_at) break;
      end
      @(negedge clk);
      chk("req_dropped", {31'b0, dmem_req}, 32'd0);
      chk("wb_timing", {31'b0, wb_valid}, 32'd1);
      chk("resp_stall", {31'b0, stall}, {31'b0, acked});
      if (stall) stalls++;
      @(posedge clk); #1;
      chk("stall_cycles", 32'(stalls), acked ? 32'(ack_at + 2) : 32'(TMO + 1));
    end else begin
      @(negedge clk);
      chk("wb_timing", {31'b0, wb_valid}, 32'd1);
      chk("no_bus_req", {31'b0, dmem_req}, 32'd0);
      chk("no_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("stall_cycles", 32'(stalls), 32'd0);
    end
    last_stalls = stalls;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_write_reg", {31'b0, write_regM}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Plain ALU pass-through.
    run_op(LNONE, SNONE, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    chk("alu_lit_data", last_wb_data, 32'h00001234);
    run_op(LNONE, SNONE, 32'hDEADBEEF, 32'h0, 5'd7, 1'b0, 0, 32'h0);

    // Byte store at top lane, ack on third REQ cycle.
    run_op(LNONE, SB, 32'h103, 32'hAB, 5'd1, 1'b1, 3, 32'h0);
    chk("sb_lit_be", {28'b0, last_be}, 32'h8);
    chk("sb_lit_wdata", last_wdata, 32'hABABABAB);
    chk("sb_lit_stalls", 32'(last_stalls), 32'd5);

    // Byte loads, signed and unsigned.
    run_op(LB, SNONE, 32'h102, 32'h0, 5'd3, 1'b1, 1, 32'h00800000);
    chk("lb_lit_data", last_wb_data, 32'hFFFFFF80);
    run_op(LBU, SNONE, 32'h102, 32'h0, 5'd4, 1'b1, 2, 32'h00800000);
    chk("lbu_lit_data", last_wb_data, 32'h00000080);

    // Halfword loads in the upper lane.
    run_op(LH, SNONE, 32'h102, 32'h0, 5'd8, 1'b1, 1, 32'h80010000);
    chk("lh_lit_data", last_wb_data, 32'hFFFF8001);
    run_op(LHU, SNONE, 32'h106, 32'h0, 5'd9, 1'b1, 4, 32'h80010000);
    chk("lhu_lit_data", last_wb_data, 32'h00008001);

    // Misaligned accesses never touch the bus.
    run_op(LH, SNONE, 32'h101, 32'h0, 5'd10, 1'b1, 1, 32'h0);
    run_op(LNONE, SW, 32'h302, 32'h55, 5'd11, 1'b0, 1, 32'h0);

    // Halfword and word stores.
    run_op(LNONE, SH, 32'h202, 32'h1234CAFE, 5'd12, 1'b0, 1, 32'h0);
    chk("sh_lit_be", {28'b0, last_be}, 32'hC);
    chk("sh_lit_wdata", last_wdata, 32'hCAFECAFE);
    run_op(LNONE, SW, 32'h300, 32'h01020304, 5'd13, 1'b1, 2, 32'h0);

    // Ack on the very cycle the timeout would fire is a success.
    run_op(LW, SNONE, 32'h304, 32'h0, 5'd14, 1'b1, TMO, 32'h13579BDF);
    chk("lw_lit_data", last_wb_data, 32'h13579BDF);

    // No ack at all: bus error after TMO REQ cycles.
    run_op(LW, SNONE, 32'h200, 32'h0, 5'd15, 1'b1, 0, 32'h0);
    chk("tmo_lit_stalls", 32'(last_stalls), 32'd17);

    // Load and store both set: treated as a load.
    run_op(LW, SW, 32'h400, 32'hFFFFFFFF, 5'd16, 1'b1, 1, 32'hA5A5A5A5);

    // Reset in the middle of REQ discards the instruction.
    in_valid = 1; alu_result = 32'h500; info_loadE = LW; info_storeE = SNONE;
    dstreg_addrE = 5'd17; write_regE = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("mid_req_high", {31'b0, dmem_req}, 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_rst_req_drop", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_wb", {31'b0, wb_valid}, 32'd0);
      chk("post_rst_no_req", {31'b0, dmem_req}, 32'd0);
    end

    // ALU op works after reset recovery.
    @(posedge clk); #1;
    run_op(LNONE, SNONE, 32'h0BADF00D, 32'h0, 5'd18, 1'b1, 0, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
